// File: rtl/channel_phase_generator_if.sv
// Command handshake for the channel phase generator: a note step offered
// with valid/ready flow control.
interface channel_phase_generator_if #(
  parameter int unsigned STEP_W = 16
);
  logic              note_valid;
  logic              note_ready;
  logic [STEP_W-1:0] note_step;

  modport master (
    output note_valid,
    output note_step,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_step,
    output note_ready
  );
endinterface

// File: rtl/channel_phase_generator.sv
// Channel phase generator: advances an 8-bit phase index every note_step
// clock cycles. Retunes are held pending and applied at the next waveform
// wrap; a zero step requests a stop that also completes at the next wrap.
module channel_phase_generator #(
  parameter int unsigned STEP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  channel_phase_generator_if.slave note,
  output logic [7:0]               period,
  output logic                     phase_tick,
  output logic                     phase_wrap,
  output logic                     active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] div_cnt;
  logic [STEP_W-1:0] step_reg;
  logic [STEP_W-1:0] pend_step;
  logic              pend_valid;
  logic              ready;
  logic              accept;
  logic              step_nz;

  assign note.note_ready = ready;

  // Status outputs decoded from registered state only (no input paths).
  always_comb begin
    active     = (state != IDLE);
    phase_tick = (state != IDLE) && (div_cnt == step_reg - STEP_ONE);
    phase_wrap = phase_tick && (period == 8'hFF);
  end

  // Handshake ready and command qualification.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     ready = !pend_valid;
      default: ready = 1'b0;
    endcase
    accept  = note.note_valid && ready;
    step_nz = |note.note_step;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && step_nz) state_nx = RUN;
      RUN:     if (accept && !step_nz) state_nx = STOP;
      STOP:    if (phase_wrap) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Divider, phase index and pending-retune registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      step_reg   <= '0;
      pend_step  <= '0;
      pend_valid <= 1'b0;
      period     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && step_nz) begin
            step_reg <= note.note_step;
            div_cnt  <= '0;
          end
        end
        RUN, STOP: begin
          // A wrap in STOP lands period on 0 and div_cnt on 0 through the
          // normal tick path, which is exactly the IDLE entry condition.
          if (phase_tick) begin
            div_cnt <= '0;
            period  <= period + 8'd1;
          end else begin
            div_cnt <= div_cnt + STEP_ONE;
          end
          if (state == RUN) begin
            if (phase_wrap && pend_valid) begin
              step_reg   <= pend_step;
              pend_valid <= 1'b0;
            end
            // Accept implies pend_valid was 0, so this never races the
            // retune above; a command taken at a wrap waits for the next.
            if (accept) begin
              if (step_nz) begin
                pend_step  <= note.note_step;
                pend_valid <= 1'b1;
              end else begin
                pend_valid <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_phase_generator.sv
// Bench for channel_phase_generator: a countdown-based behavioural model is
// compared against the DUT on every falling edge, with directed scenarios
// and randomized commands, plus literal expectations on key timings.
module tb_channel_phase_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] period;
  logic       phase_tick;
  logic       phase_wrap;
  logic       active;

  int checks = 0;
  int errors = 0;

  channel_phase_generator_if #(.STEP_W(16)) note ();

  channel_phase_generator #(.STEP_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note       (note),
    .period     (period),
    .phase_tick (phase_tick),
    .phase_wrap (phase_wrap),
    .active     (active)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 run, 2 stop; m_left counts cycles to next tick.
  int m_mode = 0;
  int m_period = 0;
  int m_left = 0;
  int m_step = 0;
  int m_pend[$];

  function automatic bit m_ready();
    return (m_mode == 0) || (m_mode == 1 && m_pend.size() == 0);
  endfunction

  function automatic bit m_tick();
    return (m_mode != 0) && (m_left == 1);
  endfunction

  function automatic bit m_wrap();
    return m_tick() && (m_period == 255);
  endfunction

  function automatic void m_reset();
    m_mode = 0;
    m_period = 0;
    m_left = 0;
    m_step = 0;
    m_pend.delete();
  endfunction

  function automatic void m_edge(input bit v, input int s);
    bit acc;
    bit tk;
    bit wr;
    int mode0;
    acc = v && m_ready();
    tk = m_tick();
    wr = m_wrap();
    mode0 = m_mode;
    if (mode0 == 0) begin
      if (acc && s != 0) begin
        m_mode = 1;
        m_step = s;
        m_left = s;
      end
    end else begin
      if (tk) begin
        m_period = (m_period + 1) % 256;
        if (wr && mode0 == 2) begin
          m_mode = 0;
          m_period = 0;
        end else if (wr && m_pend.size() > 0) begin
          m_step = m_pend.pop_front();
        end
        m_left = m_step;
      end else begin
        m_left = m_left - 1;
      end
      if (mode0 == 1 && acc) begin
        if (s != 0) m_pend.push_back(s);
        else begin
          m_mode = 2;
          m_pend.delete();
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_edge(note.note_valid, int'(note.note_step));
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("period", int'(period), m_period);
    chk("phase_tick", int'(phase_tick), int'(m_tick()));
    chk("phase_wrap", int'(phase_wrap), int'(m_wrap()));
    chk("active", int'(active), int'(m_mode != 0));
    chk("note_ready", int'(note.note_ready), int'(m_ready()));
  end

  // Drive a command and hold it until accepted; call just after a rising edge.
  task automatic send(input int s);
    bit ok;
    ok = 1'b0;
    note.note_valid = 1'b1;
    note.note_step = 16'(s);
    for (int i = 0; i < 3000 && !ok; i++) begin
      ok = note.note_ready;
      @(posedge clk);
      #1;
    end
    note.note_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic edges_until_period(input int p, output int n);
    n = 0;
    while (int'(period) != p && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (active && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idle", int'(active), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int wc;
    int r;
    int s;
    note.note_valid = 1'b0;
    note.note_step = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_ready", int'(note.note_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero step in IDLE is consumed without effect.
    send(0);
    chk("idle_zero_active", int'(active), 0);

    // Start with step 4.
    send(4);
    chk("start_active", int'(active), 1);
    edges_until_period(1, n);
    chk("start_first_tick", n, 4);
    edges_until_period(2, n);
    chk("start_second_tick", n, 4);
    chk("model_pin_period", m_period, 2);
    send(0);
    wait_idle();

    // Step 1: exactly two wraps in 512 cycles.
    send(1);
    wc = 0;
    for (int i = 0; i < 512; i++) begin
      wc += int'(phase_wrap);
      @(posedge clk);
      #1;
    end
    chk("wrap_count", wc, 2);
    send(0);
    wait_idle();

    // Retune: step 2, pend step 3 around period 10.
    send(2);
    edges_until_period(10, n);
    send(3);
    chk("retune_ready_low", int'(note.note_ready), 0);
    edges_until_period((int'(period) + 1) % 256, n);
    edges_until_period((int'(period) + 1) % 256, n);
    chk("retune_old_spacing", n, 2);
    n = 0;
    while (!note.note_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("retune_period_at_apply", int'(period), 0);
    edges_until_period(1, n);
    chk("retune_new_spacing_a", n, 3);
    edges_until_period(2, n);
    chk("retune_new_spacing_b", n, 3);
    send(0);
    wait_idle();

    // Stop from step 1 at period 100.
    send(1);
    edges_until_period(100, n);
    send(0);
    chk("stop_ready_low", int'(note.note_ready), 0);
    chk("stop_still_active", int'(active), 1);
    wait_idle();
    chk("stop_period_zero", int'(period), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("stop_period_held", int'(period), 0);

    // Pending command accepted on the wrap edge applies one wrap later.
    send(1);
    n = 0;
    while (!phase_wrap && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sim_wrap_seen", int'(phase_wrap), 1);
    note.note_valid = 1'b1;
    note.note_step = 16'd5;
    @(posedge clk);
    #1;
    note.note_valid = 1'b0;
    n = 0;
    while (!note.note_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sim_apply_delay", n, 256);
    edges_until_period(1, n);
    chk("sim_new_spacing", n, 5);

    // Asynchronous reset mid-run at period 77.
    edges_until_period(77, n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_active", int'(active), 0);
    chk("arst_ready", int'(note.note_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(2);
    chk("arst_restart_active", int'(active), 1);
    edges_until_period(1, n);
    chk("arst_restart_tick", n, 2);

    // Randomized commands with one asynchronous reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(9, 0));
      s = (r < 2) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : int'($urandom_range(6, 3));
      note.note_valid = ($urandom_range(5, 0) == 0);
      note.note_step = 16'(s);
      if (c == 2000) begin
        #3;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    note.note_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
